// File: rtl/auth_msg_tx_router.sv
// Byte-serial transmitter for authentication messages: latches one message,
// streams it MSB-first to the PD or DEBUG channel, then acks or drops on stall.
module auth_msg_tx_router #(
    parameter int MSG_LEN     = 2048,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               auth_msg_ready,
    input  logic [MSG_LEN-1:0] auth_msg_out,
    input  logic               msg_dest,
    input  logic               PD_ready,
    input  logic               DEBUG_ready,
    output logic [7:0]         PD_byte,
    output logic               PD_byte_valid,
    output logic               PD_byte_last,
    output logic [7:0]         DEBUG_byte,
    output logic               DEBUG_byte_valid,
    output logic               DEBUG_byte_last,
    output logic               Ack_in_driver,
    output logic               tx_busy,
    output logic               tx_timeout
);

    localparam int NBYTES = MSG_LEN / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [MSG_LEN-1:0] buf_q, buf_d;
    logic               dest_q, dest_d;
    logic               sel_ready_s;
    logic [7:0]         cur_byte_s;

    logic [7:0] pd_byte_q, pd_byte_d;
    logic       pd_valid_q, pd_valid_d;
    logic       pd_last_q, pd_last_d;
    logic [7:0] dbg_byte_q, dbg_byte_d;
    logic       dbg_valid_q, dbg_valid_d;
    logic       dbg_last_q, dbg_last_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    // Only the latched destination's ready matters; the other channel is ignored.
    assign sel_ready_s = dest_q ? DEBUG_ready : PD_ready;

    // Next-state, index and stall-counter logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        buf_d   = buf_q;
        dest_d  = dest_q;
        case (state_q)
            IDLE: begin
                if (auth_msg_ready) begin
                    buf_d   = auth_msg_out;
                    dest_d  = msg_dest;
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                // A transfer on the limit cycle beats the timeout.
                if (sel_ready_s) begin
                    tmo_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ACK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d = DROP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ACK:     state_d = IDLE;
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with no extra latency.
    always_comb begin
        cur_byte_s  = buf_d[(MSG_LEN - 1) - 8 * int'(idx_d) -: 8];
        pd_byte_d   = 8'h00;
        pd_valid_d  = 1'b0;
        pd_last_d   = 1'b0;
        dbg_byte_d  = 8'h00;
        dbg_valid_d = 1'b0;
        dbg_last_d  = 1'b0;
        if (state_d == SEND) begin
            if (dest_d) begin
                dbg_byte_d  = cur_byte_s;
                dbg_valid_d = 1'b1;
                dbg_last_d  = (idx_d == LAST_IDX);
            end else begin
                pd_byte_d  = cur_byte_s;
                pd_valid_d = 1'b1;
                pd_last_d  = (idx_d == LAST_IDX);
            end
        end else begin
            pd_valid_d  = 1'b0;
            dbg_valid_d = 1'b0;
        end
        ack_d     = (state_d == ACK);
        busy_d    = (state_d != IDLE);
        timeout_d = (state_d == DROP);
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            buf_q   <= '0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            buf_q   <= buf_d;
            dest_q  <= dest_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pd_byte_q   <= 8'h00;
            pd_valid_q  <= 1'b0;
            pd_last_q   <= 1'b0;
            dbg_byte_q  <= 8'h00;
            dbg_valid_q <= 1'b0;
            dbg_last_q  <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            pd_byte_q   <= pd_byte_d;
            pd_valid_q  <= pd_valid_d;
            pd_last_q   <= pd_last_d;
            dbg_byte_q  <= dbg_byte_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_last_q  <= dbg_last_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PD_byte          = pd_byte_q;
    assign PD_byte_valid    = pd_valid_q;
    assign PD_byte_last     = pd_last_q;
    assign DEBUG_byte       = dbg_byte_q;
    assign DEBUG_byte_valid = dbg_valid_q;
    assign DEBUG_byte_last  = dbg_last_q;
    assign Ack_in_driver    = ack_q;
    assign tx_busy          = busy_q;
    assign tx_timeout       = timeout_q;

endmodule

// File: tb/tb_auth_msg_tx_router.sv
// Directed bench for auth_msg_tx_router with 32-bit messages and an 8-cycle stall limit.
module tb_auth_msg_tx_router;

    localparam int MSG_LEN     = 32;
    localparam int TIMEOUT_CYC = 8;

    logic               clk;
    logic               reset;
    logic               auth_msg_ready;
    logic [MSG_LEN-1:0] auth_msg_out;
    logic               msg_dest;
    logic               PD_ready;
    logic               DEBUG_ready;
    logic [7:0]         PD_byte;
    logic               PD_byte_valid;
    logic               PD_byte_last;
    logic [7:0]         DEBUG_byte;
    logic               DEBUG_byte_valid;
    logic               DEBUG_byte_last;
    logic               Ack_in_driver;
    logic               tx_busy;
    logic               tx_timeout;

    int vec_cnt;
    int err_cnt;

    auth_msg_tx_router #(.MSG_LEN(MSG_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk              (clk),
        .reset            (reset),
        .auth_msg_ready   (auth_msg_ready),
        .auth_msg_out     (auth_msg_out),
        .msg_dest         (msg_dest),
        .PD_ready         (PD_ready),
        .DEBUG_ready      (DEBUG_ready),
        .PD_byte          (PD_byte),
        .PD_byte_valid    (PD_byte_valid),
        .PD_byte_last     (PD_byte_last),
        .DEBUG_byte       (DEBUG_byte),
        .DEBUG_byte_valid (DEBUG_byte_valid),
        .DEBUG_byte_last  (DEBUG_byte_last),
        .Ack_in_driver    (Ack_in_driver),
        .tx_busy          (tx_busy),
        .tx_timeout       (tx_timeout)
    );

    // Observed output bundle: {PD byte,valid,last, DEBUG byte,valid,last, ack, busy, timeout}
    logic [22:0] outs_s;
    assign outs_s = {PD_byte, PD_byte_valid, PD_byte_last,
                     DEBUG_byte, DEBUG_byte_valid, DEBUG_byte_last,
                     Ack_in_driver, tx_busy, tx_timeout};

    localparam logic [22:0] E_IDLE = 23'h000000;
    localparam logic [22:0] E_ACK  = {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [22:0] E_DROP = {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] e_byte(input logic dest, input logic [7:0] b, input logic last);
        if (dest) begin
            return {8'h00, 1'b0, 1'b0, b, 1'b1, last, 1'b0, 1'b1, 1'b0};
        end else begin
            return {b, 1'b1, last, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        end
    endfunction

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a message for exactly one sampling edge.
    task automatic launch(input logic [31:0] msg, input logic dest);
        auth_msg_ready = 1'b1;
        auth_msg_out   = msg;
        msg_dest       = dest;
        tick();
        auth_msg_ready = 1'b0;
    endtask

    // Full-rate delivery with the selected ready held high.
    task automatic deliver(input string tag, input logic [31:0] msg, input logic dest);
        launch(msg, dest);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_b%0d", tag, k), outs_s, e_byte(dest, msg[31-8*k -: 8], k == 3));
            tick();
        end
        chk({tag, "_ack"}, outs_s, E_ACK);
        tick();
        chk({tag, "_idle"}, outs_s, E_IDLE);
    endtask

    initial begin
        logic [31:0] m;
        vec_cnt        = 0;
        err_cnt        = 0;
        reset          = 1'b0;
        auth_msg_ready = 1'b1;
        auth_msg_out   = 32'h5A5A5A5A;
        msg_dest       = 1'b0;
        PD_ready       = 1'b1;
        DEBUG_ready    = 1'b1;
        tick();
        tick();
        chk("reset", outs_s, E_IDLE);
        auth_msg_ready = 1'b0;
        reset          = 1'b1;
        tick();
        chk("post_reset_idle", outs_s, E_IDLE);

        // Basic PD delivery, DEBUG ready low.
        DEBUG_ready = 1'b0;
        deliver("pd", 32'hA1B2C3D4, 1'b0);

        // DEBUG with toggling ready; PD_ready high must not matter.
        m = 32'h11223344;
        PD_ready = 1'b1;
        DEBUG_ready = 1'b0;
        launch(m, 1'b1);
        chk("dbg_first", outs_s, e_byte(1'b1, m[31 -: 8], 1'b0));
        for (int k = 0; k < 4; k++) begin
            DEBUG_ready = 1'b0;
            tick();
            chk($sformatf("dbg_hold%0d", k), outs_s, e_byte(1'b1, m[31-8*k -: 8], k == 3));
            DEBUG_ready = 1'b1;
            tick();
            if (k < 3) begin
                chk($sformatf("dbg_adv%0d", k), outs_s, e_byte(1'b1, m[23-8*k -: 8], k == 2));
            end else begin
                chk("dbg_ack", outs_s, E_ACK);
            end
        end
        DEBUG_ready = 1'b0;
        tick();
        chk("dbg_idle", outs_s, E_IDLE);

        // Timeout: 8 stalled cycles drop the message.
        PD_ready = 1'b0;
        launch(32'hCAFEBABE, 1'b0);
        chk("to_first", outs_s, e_byte(1'b0, 8'hCA, 1'b0));
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("to_stall%0d", i), outs_s, e_byte(1'b0, 8'hCA, 1'b0));
        end
        tick();
        chk("to_drop", outs_s, E_DROP);
        tick();
        chk("to_idle", outs_s, E_IDLE);
        PD_ready = 1'b1;
        deliver("to_next", 32'h55667788, 1'b0);

        // Boundary: ready rises on the limit cycle; transfer wins and counter clears.
        PD_ready = 1'b0;
        launch(32'hDEADBEEF, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("bd_stall%0d", i), outs_s, e_byte(1'b0, 8'hDE, 1'b0));
        end
        PD_ready = 1'b1;
        tick();
        chk("bd_win", outs_s, e_byte(1'b0, 8'hAD, 1'b0));
        PD_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("bd_restall%0d", i), outs_s, e_byte(1'b0, 8'hAD, 1'b0));
        end
        PD_ready = 1'b1;
        tick();
        chk("bd_b2", outs_s, e_byte(1'b0, 8'hBE, 1'b0));
        tick();
        chk("bd_b3", outs_s, e_byte(1'b0, 8'hEF, 1'b1));
        tick();
        chk("bd_ack", outs_s, E_ACK);
        tick();
        chk("bd_idle", outs_s, E_IDLE);

        // Busy ignore: new request held through SEND and ACK is taken only from IDLE.
        PD_ready = 1'b1;
        DEBUG_ready = 1'b0;
        launch(32'h12345678, 1'b0);
        chk("bi_b0", outs_s, e_byte(1'b0, 8'h12, 1'b0));
        auth_msg_ready = 1'b1;
        auth_msg_out   = 32'hFFFFFFFF;
        msg_dest       = 1'b1;
        tick();
        chk("bi_b1", outs_s, e_byte(1'b0, 8'h34, 1'b0));
        tick();
        chk("bi_b2", outs_s, e_byte(1'b0, 8'h56, 1'b0));
        tick();
        chk("bi_b3", outs_s, e_byte(1'b0, 8'h78, 1'b1));
        tick();
        chk("bi_ack", outs_s, E_ACK);
        tick();
        chk("bi_idle", outs_s, E_IDLE);
        tick();
        chk("bi_accept", outs_s, e_byte(1'b1, 8'hFF, 1'b0));
        auth_msg_ready = 1'b0;
        DEBUG_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("bi_ff%0d", k), outs_s, e_byte(1'b1, 8'hFF, k == 3));
        end
        tick();
        chk("bi_ff_ack", outs_s, E_ACK);
        tick();

        // Reset mid-message discards it silently.
        PD_ready = 1'b1;
        launch(32'hA0A1A2A3, 1'b0);
        chk("rm_b0", outs_s, e_byte(1'b0, 8'hA0, 1'b0));
        tick();
        chk("rm_b1", outs_s, e_byte(1'b0, 8'hA1, 1'b0));
        tick();
        chk("rm_b2", outs_s, e_byte(1'b0, 8'hA2, 1'b0));
        reset = 1'b0;
        tick();
        chk("rm_reset", outs_s, E_IDLE);
        reset = 1'b1;
        tick();
        chk("rm_no_ack", outs_s, E_IDLE);
        deliver("rm_next", 32'h01020304, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
